main_fsm: RTL and testbench
===========================

// Module: main_fsm
// PURPOSE
//  Multicycle control FSM for the ARM-subset core; sits upstream of the conditional-execution logic.
//  Sequences fetch/decode/execute/writeback from Op/Funct.
//  Drives raw enables NextPC, RegW, MemW, Branch (Branch becomes PCS) and the datapath mux selects.
//  Waits on a memory-ready handshake.
//  Raises a sticky Fault on an illegal opcode or a memory wait timeout.
// PARAMETERS
//  WAIT_LIMIT  15  max cycles a state may wait for MemReady before FAULT (1..255)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  Op         in   2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 illegal
//  Funct      in   6  instr[25:20]: [5]=I (immediate), [0]=S/L (load when Op=01)
//  MemReady   in   1  memory completes current access this cycle
//  IRWrite    out  1  load instruction register
//  AdrSrc     out  1  0=PC, 1=ALU result as memory address
//  ALUSrcA    out  2  00=Rn, 01=PC (others reserved)
//  ALUSrcB    out  2  00=Rm, 01=ExtImm, 10=const 4
//  ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALU result
//  ALUOp      out  1  1=decode Funct in ALU decoder, 0=add
//  NextPC     out  1  PC update request (unconditional)
//  RegW       out  1  raw register write (gated downstream by condition)
//  MemW       out  1  raw memory write (gated downstream)
//  Branch     out  1  branch request (becomes PCS downstream)
//  Fault      out  1  sticky fault flag
// BEHAVIOUR
//  Reset (reset=0): state<=FETCH, wait counter<=0, Fault<=0.
//  While reset=0, IRWrite/NextPC/RegW/MemW/Branch are forced to 0.
//  Moore outputs decoded from state; unlisted outputs are 0.
//  FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
//    IRWrite=NextPC=MemReady. Stay until MemReady, then go to DECODE.
//  DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
//    Next: Op=01->MEMADR; Op=00 & I->EXECUTEI; Op=00 & !I->EXECUTER; Op=10->BRANCH; Op=11->FAULT.
//  MEMADR: ALUSrcB=01. Next: L=1 -> MEMREAD, else MEMWRITE.
//  MEMREAD: AdrSrc=1. Stay until MemReady, then MEMWB.
//  MEMWB: ResultSrc=01, RegW=1 -> FETCH.
//  MEMWRITE: AdrSrc=1, MemW=1 held every cycle until MemReady -> FETCH.
//  EXECUTER: ALUSrcB=00, ALUOp=1 -> ALUWB.  EXECUTEI: ALUSrcB=01, ALUOp=1 -> ALUWB.
//  ALUWB: RegW=1 -> FETCH.
//  BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
//  FAULT: all enables 0, Fault=1; absorbing until reset.
//  Wait counter (8 bit):
//    - Clears on every state change and in any cycle with MemReady=1.
//    - Increments each waiting cycle in FETCH/MEMREAD/MEMWRITE.
//    - Counter==WAIT_LIMIT-1 with MemReady=0 -> FAULT next cycle.
//    - MemReady on the limit cycle wins (no fault).
//  Latency without waits: DP 4, LDR 5, STR 4, B 3 cycles.
//  Reset mid-access: async return to FETCH; enables drop immediately, no partial write repeats.
// STRUCTURE
//  ctrl_pkg holds:
//    - statetype enum (FETCH..FAULT)
//    - localparams for ALUSrcA/ALUSrcB/ResultSrc encodings
//    - OP_DP/OP_MEM/OP_BR codes
//  Sub-module mem_wait_timer (#WAIT_LIMIT): clr, waiting -> timeout.
//  main_fsm holds the state flop (async clear) and next-state/output decode.
// TESTING
//  1 ADD reg, MemReady=1 always: states F,D,ER,AW; RegW=1 only in cycle 4, NextPC=1 only in cycle 1.
//  2 LDR with MemReady low 3 cycles in MEMREAD: MEMREAD held 4 cycles; ResultSrc=01, RegW=1 once afterwards.
//  3 STR: MemW=1 in every MEMWRITE cycle until MemReady; next cycle FETCH with MemW=0.
//  4 Op=11 in DECODE -> Fault=1 next cycle; stays 1 for 20 cycles; reset=0 clears Fault, state=FETCH.
//  5 FETCH with MemReady=0 for WAIT_LIMIT cycles -> Fault=1; repeat with MemReady=1 on cycle WAIT_LIMIT -> no fault.
//  6 Assert reset=0 mid MEMWRITE: MemW drops in the same cycle; after release, FETCH with IRWrite=MemReady.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control FSM.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    FAULT
  } statetype;

  localparam logic [1:0] SRCA_RN      = 2'b00;
  localparam logic [1:0] SRCA_PC      = 2'b01;
  localparam logic [1:0] SRCB_RM      = 2'b00;
  localparam logic [1:0] SRCB_IMM     = 2'b01;
  localparam logic [1:0] SRCB_FOUR    = 2'b10;
  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_READDATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // States that stall on the memory handshake and are subject to the timeout.
  function automatic logic isWaitState(statetype s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Controller-to-datapath bundle: instruction fields and memory handshake in, enables and mux selects out.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       Fault;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, Fault
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, Fault
  );
endinterface

// File: rtl/main_fsm_mem_wait_timer.sv
// Counts consecutive stalled cycles on the memory handshake and flags the last allowed one.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic waiting,
  output logic timeout
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (waiting) begin
      count <= count + 8'd1;
    end
  end

  assign timeout = waiting && (count == LIMIT_M1);

endmodule

// File: rtl/main_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/writeback and raises a sticky fault.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic           clk,
  input  logic           reset,
  main_fsm_if.master     bus
);

  statetype state, nextState;
  logic timeout, waiting, timerClr;
  logic irWrite, nextPc, regW, memW, branch;
  logic unusedFunct;

  assign unusedFunct = ^bus.Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  // The timer restarts whenever the state moves or memory answers.
  assign waiting  = isWaitState(state) && !bus.MemReady;
  assign timerClr = bus.MemReady || (nextState != state);

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) waitTimer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timerClr),
    .waiting (waiting),
    .timeout (timeout)
  );

  always_comb begin
    nextState = state;
    case (state)
      FETCH:    if (bus.MemReady) nextState = DECODE;
                else if (timeout) nextState = FAULT;
      DECODE: begin
        case (bus.Op)
          OP_MEM:  nextState = MEMADR;
          OP_DP:   nextState = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   nextState = BRANCH;
          default: nextState = FAULT;
        endcase
      end
      MEMADR:   nextState = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.MemReady) nextState = MEMWB;
                else if (timeout) nextState = FAULT;
      MEMWB:    nextState = FETCH;
      MEMWRITE: if (bus.MemReady) nextState = FETCH;
                else if (timeout) nextState = FAULT;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BRANCH:   nextState = FETCH;
      default:  nextState = FAULT;
    endcase
  end

  // Moore decode of mux selects and raw enables.
  always_comb begin
    irWrite       = 1'b0;
    nextPc        = 1'b0;
    regW          = 1'b0;
    memW          = 1'b0;
    branch        = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = SRCA_RN;
    bus.ALUSrcB   = SRCB_RM;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUOp     = 1'b0;
    bus.Fault     = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        irWrite       = bus.MemReady;
        nextPc        = bus.MemReady;
      end
      DECODE: begin
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
      end
      MEMADR:   bus.ALUSrcB = SRCB_IMM;
      MEMREAD:  bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = RES_READDATA;
        regW          = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        memW       = 1'b1;
      end
      EXECUTER: bus.ALUOp = 1'b1;
      EXECUTEI: begin
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = 1'b1;
      end
      ALUWB:    regW = 1'b1;
      BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALU;
        branch        = 1'b1;
      end
      FAULT:    bus.Fault = 1'b1;
      default:  bus.Fault = 1'b1;
    endcase
  end

  // Enables must fall the instant reset asserts, before the async state clear propagates.
  assign bus.IRWrite = irWrite & reset;
  assign bus.NextPC  = nextPc & reset;
  assign bus.RegW    = regW & reset;
  assign bus.MemW    = memW & reset;
  assign bus.Branch  = branch & reset;

endmodule

// File: tb/tb_main_fsm.sv
// Directed-vector bench for main_fsm: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_main_fsm;

  localparam int WAIT_LIMIT = 15;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Fault}
  localparam logic [13:0] V_FETCH    = 14'b0_0_01_10_10_0_0_0_0_0_0;
  localparam logic [13:0] V_FETCHR   = 14'b1_0_01_10_10_0_1_0_0_0_0;
  localparam logic [13:0] V_DECODE   = 14'b0_0_01_10_10_0_0_0_0_0_0;
  localparam logic [13:0] V_MEMADR   = 14'b0_0_00_01_00_0_0_0_0_0_0;
  localparam logic [13:0] V_MEMREAD  = 14'b0_1_00_00_00_0_0_0_0_0_0;
  localparam logic [13:0] V_MEMWB    = 14'b0_0_00_00_01_0_0_1_0_0_0;
  localparam logic [13:0] V_MEMWRITE = 14'b0_1_00_00_00_0_0_0_1_0_0;
  localparam logic [13:0] V_EXECR    = 14'b0_0_00_00_00_1_0_0_0_0_0;
  localparam logic [13:0] V_EXECI    = 14'b0_0_00_01_00_1_0_0_0_0_0;
  localparam logic [13:0] V_ALUWB    = 14'b0_0_00_00_00_0_0_1_0_0_0;
  localparam logic [13:0] V_BRANCH   = 14'b0_0_00_01_10_0_0_0_0_1_0;
  localparam logic [13:0] V_FAULT    = 14'b0_0_00_00_00_0_0_0_0_0_1;
  localparam logic [13:0] V_RESET    = 14'b0_0_01_10_10_0_0_0_0_0_0;

  typedef struct {
    logic [13:0] vec;
    string       name;
  } expT;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;
  expT  expQ[$];

  main_fsm_if bus();

  main_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input logic memReady, input logic rst,
                               input logic [13:0] vec, input string name);
    expT e;
    @(posedge clk);
    #1;
    bus.Op       = op;
    bus.Funct    = funct;
    bus.MemReady = memReady;
    reset        = rst;
    e.vec  = vec;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e, input logic [13:0] actual);
    checkCount++;
    if (actual !== e.vec) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", e.name, actual, e.vec);
    end
  endtask

  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e, {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                        bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.Fault});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount   = 0;
    failCount    = 0;
    reset        = 1'b0;
    bus.Op       = 2'b00;
    bus.Funct    = 6'h00;
    bus.MemReady = 1'b0;

    applyStimulus(2'b00, 6'h00, 1'b1, 1'b0, V_RESET, "resetForced");

    // ADD register form
    applyStimulus(2'b00, 6'h00, 1'b1, 1'b1, V_FETCHR, "addFetch");
    applyStimulus(2'b00, 6'h00, 1'b1, 1'b1, V_DECODE, "addDecode");
    applyStimulus(2'b00, 6'h00, 1'b1, 1'b1, V_EXECR,  "addExecR");
    applyStimulus(2'b00, 6'h00, 1'b1, 1'b1, V_ALUWB,  "addAluWb");

    // ADD immediate form
    applyStimulus(2'b00, 6'h20, 1'b1, 1'b1, V_FETCHR, "addiFetch");
    applyStimulus(2'b00, 6'h20, 1'b1, 1'b1, V_DECODE, "addiDecode");
    applyStimulus(2'b00, 6'h20, 1'b1, 1'b1, V_EXECI,  "addiExecI");
    applyStimulus(2'b00, 6'h20, 1'b1, 1'b1, V_ALUWB,  "addiAluWb");

    // LDR with three wait cycles in MEMREAD
    applyStimulus(2'b01, 6'h21, 1'b1, 1'b1, V_FETCHR, "ldrFetch");
    applyStimulus(2'b01, 6'h21, 1'b1, 1'b1, V_DECODE, "ldrDecode");
    applyStimulus(2'b01, 6'h21, 1'b1, 1'b1, V_MEMADR, "ldrMemAdr");
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b01, 6'h21, 1'b0, 1'b1, V_MEMREAD, "ldrMemReadWait");
    applyStimulus(2'b01, 6'h21, 1'b1, 1'b1, V_MEMREAD, "ldrMemReadDone");
    applyStimulus(2'b01, 6'h21, 1'b1, 1'b1, V_MEMWB,   "ldrMemWb");

    // STR with MemW held until MemReady
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_FETCHR, "strFetch");
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_DECODE, "strDecode");
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_MEMADR, "strMemAdr");
    applyStimulus(2'b01, 6'h20, 1'b0, 1'b1, V_MEMWRITE, "strMemWriteWait1");
    applyStimulus(2'b01, 6'h20, 1'b0, 1'b1, V_MEMWRITE, "strMemWriteWait2");
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_MEMWRITE, "strMemWriteDone");
    applyStimulus(2'b01, 6'h20, 1'b0, 1'b1, V_FETCH,    "strBackToFetch");

    // Branch
    applyStimulus(2'b10, 6'h00, 1'b1, 1'b1, V_FETCHR, "bFetch");
    applyStimulus(2'b10, 6'h00, 1'b1, 1'b1, V_DECODE, "bDecode");
    applyStimulus(2'b10, 6'h00, 1'b1, 1'b1, V_BRANCH, "bBranch");

    // Illegal opcode, then sticky fault cleared only by reset
    applyStimulus(2'b11, 6'h00, 1'b1, 1'b1, V_FETCHR, "illFetch");
    applyStimulus(2'b11, 6'h00, 1'b1, 1'b1, V_DECODE, "illDecode");
    for (int i = 0; i < 20; i++)
      applyStimulus(2'(i), 6'(i), 1'(i), 1'b1, V_FAULT, "illFaultSticky");
    applyStimulus(2'b00, 6'h00, 1'b0, 1'b0, V_RESET, "illResetClears");

    // FETCH timeout after WAIT_LIMIT stalled cycles
    for (int i = 0; i < WAIT_LIMIT; i++)
      applyStimulus(2'b00, 6'h00, 1'b0, 1'b1, V_FETCH, "toFetchWait");
    applyStimulus(2'b00, 6'h00, 1'b0, 1'b1, V_FAULT, "toFault");
    applyStimulus(2'b00, 6'h00, 1'b0, 1'b0, V_RESET, "toReset");

    // MemReady on the limit cycle wins
    for (int i = 0; i < WAIT_LIMIT - 1; i++)
      applyStimulus(2'b10, 6'h00, 1'b0, 1'b1, V_FETCH, "limFetchWait");
    applyStimulus(2'b10, 6'h00, 1'b1, 1'b1, V_FETCHR, "limReadyOnLimit");
    applyStimulus(2'b10, 6'h00, 1'b1, 1'b1, V_DECODE, "limNoFault");
    applyStimulus(2'b10, 6'h00, 1'b1, 1'b1, V_BRANCH, "limBranch");

    // Reset in the middle of a store
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_FETCHR,   "rstFetch");
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_DECODE,   "rstDecode");
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_MEMADR,   "rstMemAdr");
    applyStimulus(2'b01, 6'h20, 1'b0, 1'b1, V_MEMWRITE, "rstMemWrite");
    applyStimulus(2'b01, 6'h20, 1'b0, 1'b0, V_RESET,    "rstMidWrite");
    applyStimulus(2'b01, 6'h20, 1'b0, 1'b1, V_FETCH,    "rstFetchNoReady");
    applyStimulus(2'b01, 6'h20, 1'b1, 1'b1, V_FETCHR,   "rstFetchReady");

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
